// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default sizing for the memory arbiter.
// Optional feature macro used by mem_arbiter: ARB_RR_EN (round-robin I/D grant).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } arb_state_e;

  // Fill owner encoding, also the value driven on fill_owner.
  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  localparam int DEF_BLOCK_WORDS = 8;
  localparam int DEF_MEM_LATENCY = 4;
  localparam int DEF_ADDR_W      = 16;
  localparam int DATA_W          = 16;

endpackage

// File: rtl/mem_blk_seq.sv
// mem_blk_seq: issue/return word counters for one block fill.
// Both counters restart on start; the issue counter stops stepping after the
// last word so the next-address value never leaves the block.
module mem_blk_seq #(
  parameter int BLOCK_WORDS = 8,
  parameter int WORD_W      = $clog2(BLOCK_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              issue_step,
  input  logic              ret_step,
  output logic [WORD_W-1:0] issue_idx_next,
  output logic              issue_last,
  output logic [WORD_W-1:0] ret_idx,
  output logic              ret_last
);

  localparam logic [WORD_W-1:0] LAST_IDX = WORD_W'(BLOCK_WORDS - 1);

  logic [WORD_W-1:0] issue_idx_reg;
  logic [WORD_W-1:0] ret_idx_reg;

  // Word counters: cleared on a new fill, stepped per issue and per return.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      issue_idx_reg <= '0;
      ret_idx_reg   <= '0;
    end else begin
      if (issue_step) begin
        issue_idx_reg <= issue_idx_reg + WORD_W'(1);
      end
      if (ret_step) begin
        ret_idx_reg <= ret_idx_reg + WORD_W'(1);
      end
    end
  end

  assign issue_idx_next = issue_idx_reg + WORD_W'(1);
  assign issue_last     = (issue_idx_reg == LAST_IDX);
  assign ret_idx        = ret_idx_reg;
  assign ret_last       = (ret_idx_reg == LAST_IDX);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates I-cache fills, D-cache fills and D-cache
// write-through stores onto one pipelined memory port.
// Optional macro ARB_RR_EN: alternate I/D grants under contention instead of
// fixed D-over-I priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int WORD_W      = $clog2(BLOCK_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_wr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic              fill_we,
  output logic              fill_owner,
  output logic [WORD_W-1:0] fill_word,
  output logic [DATA_W-1:0] fill_data,
  output logic              i_done,
  output logic              d_done,
  output logic              busy
);

  // Byte offset bits within a block: word index plus the byte-in-word bit.
  localparam int OFF_W = WORD_W + 1;
  localparam logic [ADDR_W-1:0] BASE_MASK = {{(ADDR_W - OFF_W){1'b1}}, {OFF_W{1'b0}}};

  arb_state_e        state_reg;
  logic              owner_reg;
  logic [ADDR_W-1:0] base_reg;
  logic              mem_en_reg;
  logic              mem_wr_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;

  logic              req_i;
  logic              req_d;
  logic              req_w;
  logic              grant;
  logic              pick_d;
  logic              grant_wr;
  logic [ADDR_W-1:0] grant_base;

  logic              fill_hit;
  logic              fill_end;
  logic              seq_start;
  logic              issue_step;
  logic [WORD_W-1:0] issue_idx_next;
  logic              issue_last;
  logic [WORD_W-1:0] ret_idx;
  logic              ret_last;

`ifdef ARB_RR_EN
  logic last_d_reg;
`endif

  // Returns only count while filling; stray mem_valid elsewhere is dropped.
  assign fill_hit = (state_reg == FILL) && mem_valid;
  assign fill_end = fill_hit && ret_last;

  // Grant decision. In the done cycle of a fill the next grant is taken at
  // the same edge, with the finishing owner masked because it still holds
  // its request until it has seen done.
  always_comb begin
    req_i  = 1'b0;
    req_d  = 1'b0;
    req_w  = 1'b0;
    pick_d = 1'b0;
    if (state_reg == IDLE) begin
      req_i = i_miss;
      req_d = d_miss;
      req_w = d_wr;
    end else if (fill_end) begin
      req_i = i_miss && (owner_reg != OWNER_I);
      req_d = d_miss && (owner_reg != OWNER_D);
      req_w = d_wr   && (owner_reg != OWNER_D);
    end
`ifdef ARB_RR_EN
    pick_d = (req_d || req_w) && !(req_i && last_d_reg);
`else
    pick_d = req_d || req_w;
`endif
    grant = req_i || req_d || req_w;
  end

  assign grant_wr   = pick_d && req_w;
  assign grant_base = (pick_d ? d_addr : i_addr) & BASE_MASK;
  assign seq_start  = grant && !grant_wr;
  assign issue_step = (state_reg == FILL) && mem_en_reg && !issue_last;

  mem_blk_seq #(
    .BLOCK_WORDS(BLOCK_WORDS),
    .WORD_W     (WORD_W)
  ) u_blk_seq (
    .clk           (clk),
    .rst           (rst),
    .start         (seq_start),
    .issue_step    (issue_step),
    .ret_step      (fill_hit),
    .issue_idx_next(issue_idx_next),
    .issue_last    (issue_last),
    .ret_idx       (ret_idx),
    .ret_last      (ret_last)
  );

  // Main FSM with registered memory-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      owner_reg     <= OWNER_I;
      base_reg      <= '0;
      mem_en_reg    <= 1'b0;
      mem_wr_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else if (grant) begin
      owner_reg  <= pick_d ? OWNER_D : OWNER_I;
      mem_en_reg <= 1'b1;
      if (grant_wr) begin
        state_reg     <= WRITE;
        mem_wr_reg    <= 1'b1;
        mem_addr_reg  <= d_addr;
        mem_wdata_reg <= d_wdata;
      end else begin
        state_reg    <= FILL;
        mem_wr_reg   <= 1'b0;
        mem_addr_reg <= grant_base;
        base_reg     <= grant_base;
      end
    end else begin
      case (state_reg)
        FILL: begin
          if (mem_en_reg) begin
            if (issue_last) begin
              mem_en_reg <= 1'b0;
            end else begin
              // Word index is OR-ed into the cleared base: stays in the block.
              mem_addr_reg <= base_reg | ADDR_W'({issue_idx_next, 1'b0});
            end
          end
          if (fill_end) begin
            state_reg <= IDLE;
          end
        end
        WRITE: begin
          state_reg  <= IDLE;
          mem_en_reg <= 1'b0;
          mem_wr_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef ARB_RR_EN
  // Remember which side won the latest grant so contention alternates.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_d_reg <= 1'b0;
    end else if (grant) begin
      last_d_reg <= pick_d;
    end
  end
`endif

  assign mem_en     = mem_en_reg;
  assign mem_wr     = mem_wr_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_wdata  = mem_wdata_reg;
  assign busy       = (state_reg != IDLE);
  assign fill_we    = fill_hit;
  assign fill_owner = owner_reg;
  assign fill_word  = ret_idx;
  assign fill_data  = fill_hit ? mem_rdata : '0;
  assign i_done     = fill_end && (owner_reg == OWNER_I);
  assign d_done     = (fill_end && (owner_reg == OWNER_D)) || (state_reg == WRITE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven check of mem_arbiter against a data=address
// pipelined memory, plus hand-written reset and request-drop sequences.
// Expectations switch with ARB_RR_EN to match the grant order of that build.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int LAT  = DEF_MEM_LATENCY;
  localparam int NVEC = 45;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_miss;
  logic [15:0] i_addr;
  logic        d_miss;
  logic [15:0] d_addr;
  logic        d_wr;
  logic [15:0] d_wdata;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_valid;
  logic        fill_we;
  logic        fill_owner;
  logic [2:0]  fill_word;
  logic [15:0] fill_data;
  logic        i_done;
  logic        d_done;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.BLOCK_WORDS(8), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst),
    .i_miss(i_miss), .i_addr(i_addr),
    .d_miss(d_miss), .d_addr(d_addr), .d_wr(d_wr), .d_wdata(d_wdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .fill_we(fill_we), .fill_owner(fill_owner), .fill_word(fill_word), .fill_data(fill_data),
    .i_done(i_done), .d_done(d_done), .busy(busy)
  );

  // Pipelined memory whose read data equals the read address.
  logic [LAT-1:0] st_v = '0;
  logic [15:0]    st_a [LAT];
  always @(posedge clk) begin
    st_v    <= {st_v[LAT-2:0], mem_en && !mem_wr};
    st_a[0] <= mem_addr;
    for (int i = 1; i < LAT; i++) st_a[i] <= st_a[i-1];
  end
  assign mem_valid = st_v[LAT-1];
  assign mem_rdata = st_a[LAT-1];

  // One row per cycle: inputs driven in that cycle, outputs expected in it.
  typedef struct packed {
    logic        i_miss;
    logic [15:0] i_addr;
    logic        d_miss;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        busy;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        fill_we;
    logic        fill_owner;
    logic [2:0]  fill_word;
    logic [15:0] fill_data;
    logic        i_done;
    logic        d_done;
  } vec_t;

  vec_t tbl [NVEC];

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Expected outputs of a block fill whose first issue is in cycle s.
  task automatic exp_fill(input int s, input logic [15:0] base, input logic own);
    for (int k = 0; k < LAT + 8; k++) tbl[s+k].busy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tbl[s+k].mem_en         = 1'b1;
      tbl[s+k].mem_addr       = base + 16'(2*k);
      tbl[s+LAT+k].fill_we    = 1'b1;
      tbl[s+LAT+k].fill_owner = own;
      tbl[s+LAT+k].fill_word  = 3'(k);
      tbl[s+LAT+k].fill_data  = base + 16'(2*k);
    end
    if (own) tbl[s+LAT+7].d_done = 1'b1;
    else     tbl[s+LAT+7].i_done = 1'b1;
  endtask

  task automatic hold_i(input int a, input int b, input logic [15:0] addr);
    for (int n = a; n <= b; n++) begin tbl[n].i_miss = 1'b1; tbl[n].i_addr = addr; end
  endtask

  task automatic hold_d(input int a, input int b, input logic [15:0] addr);
    for (int n = a; n <= b; n++) begin tbl[n].d_miss = 1'b1; tbl[n].d_addr = addr; end
  endtask

  initial begin
    int nfill;
    int done_cyc;

    rst = 1'b1; i_miss = 1'b0; i_addr = '0; d_miss = 1'b0; d_addr = '0; d_wr = 1'b0; d_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",     0, 32'(busy),     32'(0));
    chk("rst_mem_en",   0, 32'(mem_en),   32'(0));
    chk("rst_mem_wr",   0, 32'(mem_wr),   32'(0));
    chk("rst_mem_addr", 0, 32'(mem_addr), 32'(0));
    chk("rst_fill_we",  0, 32'(fill_we),  32'(0));
    chk("rst_done",     0, 32'({i_done, d_done}), 32'(0));
    rst = 1'b0;

    // ---- Vector table ----
    for (int n = 0; n < NVEC; n++) tbl[n] = '0;
    // I miss on 0x1236: issues cycles 1-8, fills 5-12, i_done at 12.
    hold_i(0, 12, 16'h1236);
    exp_fill(1, 16'h1230, OWNER_I);
    // Store: request in cycle 14, memory write and d_done in cycle 15.
    for (int n = 14; n <= 15; n++) begin
      tbl[n].d_wr = 1'b1; tbl[n].d_addr = 16'h4002; tbl[n].d_wdata = 16'hBEEF;
    end
    tbl[15].busy = 1'b1; tbl[15].mem_en = 1'b1; tbl[15].mem_wr = 1'b1;
    tbl[15].mem_addr = 16'h4002; tbl[15].mem_wdata = 16'hBEEF; tbl[15].d_done = 1'b1;
    // Simultaneous I and D misses from cycle 18; the loser starts right after the winner's done.
`ifdef ARB_RR_EN
    hold_i(18, 30, 16'h300A);
    hold_d(18, 42, 16'h2004);
    exp_fill(19, 16'h3000, OWNER_I);
    exp_fill(31, 16'h2000, OWNER_D);
`else
    hold_d(18, 30, 16'h2004);
    hold_i(18, 42, 16'h300A);
    exp_fill(19, 16'h2000, OWNER_D);
    exp_fill(31, 16'h3000, OWNER_I);
`endif

    for (int n = 0; n < NVEC; n++) begin
      @(negedge clk);
      chk("busy",    n, 32'(busy),    32'(tbl[n].busy));
      chk("mem_en",  n, 32'(mem_en),  32'(tbl[n].mem_en));
      chk("mem_wr",  n, 32'(mem_wr),  32'(tbl[n].mem_wr));
      chk("fill_we", n, 32'(fill_we), 32'(tbl[n].fill_we));
      chk("i_done",  n, 32'(i_done),  32'(tbl[n].i_done));
      chk("d_done",  n, 32'(d_done),  32'(tbl[n].d_done));
      if (tbl[n].mem_en) chk("mem_addr",  n, 32'(mem_addr),  32'(tbl[n].mem_addr));
      if (tbl[n].mem_wr) chk("mem_wdata", n, 32'(mem_wdata), 32'(tbl[n].mem_wdata));
      if (tbl[n].fill_we) begin
        chk("fill_owner", n, 32'(fill_owner), 32'(tbl[n].fill_owner));
        chk("fill_word",  n, 32'(fill_word),  32'(tbl[n].fill_word));
        chk("fill_data",  n, 32'(fill_data),  32'(tbl[n].fill_data));
      end
      if (tbl[n].i_done || tbl[n].d_done)
        $display("txn cycle %0d: i_done=%0b d_done=%0b owner=%0b mem_wr=%0b", n, i_done, d_done, fill_owner, mem_wr);
      i_miss = tbl[n].i_miss; i_addr = tbl[n].i_addr;
      d_miss = tbl[n].d_miss; d_wr = tbl[n].d_wr;
      d_addr = tbl[n].d_addr; d_wdata = tbl[n].d_wdata;
    end

    // ---- Reset in cycle 6 of a fill ----
    @(negedge clk);
    i_miss = 1'b1; i_addr = 16'h1236;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 5 || c == 6) begin
        chk("rst_seq_fill_we",   c, 32'(fill_we),   32'(1));
        chk("rst_seq_fill_data", c, 32'(fill_data), 32'(16'h1230 + 16'(2*(c-5))));
      end
      if (c == 6) begin rst = 1'b1; i_miss = 1'b0; end
      if (c == 7) begin
        rst = 1'b0;
        chk("post_rst_mem_en",     c, 32'(mem_en),     32'(0));
        chk("post_rst_mem_wr",     c, 32'(mem_wr),     32'(0));
        chk("post_rst_mem_addr",   c, 32'(mem_addr),   32'(0));
        chk("post_rst_mem_wdata",  c, 32'(mem_wdata),  32'(0));
        chk("post_rst_fill_owner", c, 32'(fill_owner), 32'(0));
        chk("post_rst_fill_word",  c, 32'(fill_word),  32'(0));
        chk("post_rst_fill_data",  c, 32'(fill_data),  32'(0));
      end
      if (c >= 7) begin
        chk("post_rst_fill_we", c, 32'(fill_we), 32'(0));
        chk("post_rst_busy",    c, 32'(busy),    32'(0));
        chk("post_rst_done",    c, 32'({i_done, d_done}), 32'(0));
      end
    end
    $display("txn reset-mid-fill sequence complete");

    // ---- I request dropped in cycle 3 of its fill ----
    @(negedge clk);
    i_miss = 1'b1; i_addr = 16'h5678;
    nfill = 0; done_cyc = -1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 3) i_miss = 1'b0;
      if (fill_we) begin
        chk("drop_fill_word", c, 32'(fill_word), 32'(nfill));
        chk("drop_fill_data", c, 32'(fill_data), 32'(16'h5670 + 16'(2*nfill)));
        nfill++;
      end
      if (i_done) done_cyc = c;
      if (c == 13) chk("drop_busy_after_done", c, 32'(busy), 32'(0));
    end
    chk("drop_fill_count", 14, 32'(nfill),    32'(8));
    chk("drop_done_cycle", 14, 32'(done_cyc), 32'(12));
    $display("txn dropped-request fill: %0d words, i_done cycle %0d", nfill, done_cyc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
